// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in / imem write bus out for the boot loader
//
// Signals
//   byte_valid  source has a byte on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts the byte this cycle
//   imem_we     imem write strobe, one cycle per word
//   imem_addr   imem word address
//   imem_wdata  instruction word
// Modports
//   slave   loader side: consumes the byte stream, drives the imem write bus
//   master  environment side: produces the byte stream, observes imem writes
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time instruction loader feeding the CPU instruction memory
//
// Stream format: 2-byte big-endian word count N, 4*N big-endian instruction
// bytes, 1 byte XOR checksum over the instruction bytes.
// Ports
//   clk_i       system clock, rising edge
//   reset_i     synchronous, active-high
//   start_i     1-cycle pulse: begin or restart a load
//   bus         prog_loader_if.slave: byte stream in, imem write bus out
//   cpu_hold_o  1 = CPU must not fetch/advance
//   done_o      load finished with a good checksum (level)
//   error_o     load aborted on bad length or checksum (level)
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  prog_loader_if.slave bus,
  output logic         cpu_hold_o,
  output logic         done_o,
  output logic         error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        chk_q, chk_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              ready;
  logic              xfer;
  logic [15:0]       len_nxt;
  logic              last_word;

  assign xfer      = bus.byte_valid & ready;
  assign len_nxt   = {count_q[15:8], bus.byte_data};
  assign last_word = (16'(word_idx_q) == count_q - 16'd1);

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    // start overrides everything, including a byte transferred this cycle,
    // and throws away any partially assembled word.
    if (start_i) begin
      state_d    = S_LEN_HI;
      word_idx_d = '0;
      byte_idx_d = '0;
      shift_d    = '0;
      chk_d      = '0;
    end else begin
      case (state_q)
        S_LEN_HI: if (xfer) begin
          count_d = {bus.byte_data, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          count_d = len_nxt;
          if (len_nxt == 16'd0 || 32'(len_nxt) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
            chk_d      = '0;
          end
        end
        S_DATA: if (xfer) begin
          chk_d = chk_q ^ bus.byte_data;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            wdata_d    = {shift_q, bus.byte_data};
            byte_idx_d = '0;
            word_idx_d = word_idx_q + 1'b1;
            if (last_word) state_d = S_CHK;
          end else begin
            shift_d    = {shift_q[15:0], bus.byte_data};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        S_CHK: if (xfer) begin
          state_d = (bus.byte_data == chk_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end
  end

  // Outputs: handshake and status decode from state only
  always_comb begin
    ready      = 1'b0;
    cpu_hold_o = 1'b1;
    done_o     = 1'b0;
    error_o    = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: ready = 1'b1;
      S_DONE: begin
        done_o     = 1'b1;
        cpu_hold_o = 1'b0;
      end
      S_ERR:   error_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.byte_ready = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader against a stream-level model
module tb_prog_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic clk = 1'b0;
  logic reset, start;
  logic cpu_hold, done, error;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .bus(bus),
    .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic              exp_done, exp_err;
  logic [7:0]        stim[$];

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.imem_we) begin
      got_addr.push_back(bus.imem_addr);
      got_data.push_back(bus.imem_wdata);
    end
  end

  // Reference: interpret the stream as length / words / checksum
  task automatic model();
    int n;
    logic [7:0] chk;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({stim[0], stim[1]});
    if (n == 0 || n > MAX_WORDS) begin
      exp_err = 1'b1;
      return;
    end
    chk = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(ADDR_W'(w));
      exp_data.push_back({stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]});
      for (int k = 0; k < 4; k++) chk = chk ^ stim[2+4*w+k];
    end
    if (stim[2+4*n] == chk) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  function automatic logic [7:0] good_chk(int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 4*n; i++) c = c ^ stim[2+i];
    return c;
  endfunction

  // All drivers start and end at #1 after a rising edge
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int waited;
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      idle(1);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.byte_ready) begin
        idle(1);
        break;
      end
      idle(1);
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("FAIL byte_ready_timeout: byte_ready stayed 0 for %0d cycles, required 1", waited);
        break;
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic send_stream(input int gap_pct);
    pulse_start();
    model();
    foreach (stim[i]) send_byte(stim[i], gap_pct);
    idle(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    got_addr.delete();
    got_data.delete();
    idle(10);
    tests++;
    if ({cpu_hold, bus.byte_ready, done, error} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_status: hold/ready/done/err=%b, required 1000", {cpu_hold, bus.byte_ready, done, error});
    end
    tests++;
    if (got_addr.size() != 0 || bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_imem: writes=%0d addr=%h wdata=%h, required 0 0 0", got_addr.size(), bus.imem_addr, bus.imem_wdata);
    end
  endtask

  task automatic test_good_load();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'h00};
    stim[10] = good_chk(2);
    send_stream(0);
    tests++;
    if (got_addr.size() != 2) begin
      fails++;
      $display("FAIL good_count: writes=%0d, required 2", got_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
          fails++;
          $display("FAIL good_word%0d: addr=%h data=%h, required %h %h", i, got_addr[i], got_data[i], i, exp_data[i]);
        end
      end
    end
    tests++;
    if ({done, error, cpu_hold} !== 3'b100 || exp_done !== 1'b1) begin
      fails++;
      $display("FAIL good_status: done/err/hold=%b, required 100", {done, error, cpu_hold});
    end
    // bytes offered after completion are ignored; address/data hold
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    idle(3);
    bus.byte_valid = 1'b0;
    tests++;
    if (bus.byte_ready !== 1'b0 || done !== 1'b1 || got_addr.size() != 2 ||
        bus.imem_addr !== ADDR_W'(1) || bus.imem_wdata !== 32'h8C090004) begin
      fails++;
      $display("FAIL done_hold: ready=%b done=%b writes=%0d addr=%h wdata=%h, required 0 1 2 01 8c090004",
               bus.byte_ready, done, got_addr.size(), bus.imem_addr, bus.imem_wdata);
    end
  endtask

  task automatic test_bad_chk();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'h80};
    send_stream(0);
    tests++;
    if (got_addr.size() != 2 || got_data[0] !== 32'h20080005 || got_data[1] !== 32'h8C090004) begin
      fails++;
      $display("FAIL badchk_writes: writes=%0d, required 2 words 20080005 8c090004", got_addr.size());
    end
    tests++;
    if ({done, error, cpu_hold, bus.byte_ready} !== 4'b0110 || exp_err !== 1'b1) begin
      fails++;
      $display("FAIL badchk_status: done/err/hold/ready=%b, required 0110", {done, error, cpu_hold, bus.byte_ready});
    end
  endtask

  task automatic test_len_err();
    logic [15:0] lens[2];
    lens[0] = 16'd0;
    lens[1] = 16'(MAX_WORDS + 1);
    for (int t = 0; t < 2; t++) begin
      stim = '{lens[t][15:8], lens[t][7:0]};
      pulse_start();
      model();
      send_byte(stim[0], 0);
      send_byte(stim[1], 0);
      tests++;
      if ({error, done, cpu_hold, bus.byte_ready} !== {exp_err, 3'b010}) begin
        fails++;
        $display("FAIL len_err%0d: err/done/hold/ready=%b, required 1010", t, {error, done, cpu_hold, bus.byte_ready});
      end
      idle(3);
      tests++;
      if (got_addr.size() != 0 || error !== 1'b1) begin
        fails++;
        $display("FAIL len_err%0d_nowrite: writes=%0d err=%b, required 0 1", t, got_addr.size(), error);
      end
    end
  endtask

  task automatic test_gaps_and_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      stim.delete();
      n = (it == 0) ? 2 : int'($urandom_range(1, 6));
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom));
      stim.push_back(good_chk(n) ^ ((it > 0 && $urandom_range(1) == 1) ? 8'(1 << $urandom_range(7)) : 8'h00));
      send_stream(it == 0 ? 50 : 30);
      tests++;
      if (got_addr.size() != exp_addr.size()) begin
        fails++;
        $display("FAIL rand%0d_count: writes=%0d, required %0d", it, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          tests++;
          if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            fails++;
            $display("FAIL rand%0d_word%0d: addr=%h data=%h, required %h %h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      tests++;
      if (done !== exp_done || error !== exp_err || cpu_hold !== ~exp_done) begin
        fails++;
        $display("FAIL rand%0d_status: done/err/hold=%b%b%b, required %b%b%b", it, done, error, cpu_hold, exp_done, exp_err, ~exp_done);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] partial[8];
    partial = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
    pulse_start();
    foreach (partial[i]) send_byte(partial[i], 0);
    stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C};
    send_stream(0);
    tests++;
    if (got_addr.size() != 1) begin
      fails++;
      $display("FAIL abort_count: writes=%0d, required 1", got_addr.size());
    end else begin
      tests++;
      if (got_addr[0] !== '0 || got_data[0] !== 32'h0000000C) begin
        fails++;
        $display("FAIL abort_word: addr=%h data=%h, required 00 0000000c", got_addr[0], got_data[0]);
      end
    end
    tests++;
    if ({done, error, cpu_hold} !== 3'b100 || exp_done !== 1'b1) begin
      fails++;
      $display("FAIL abort_status: done/err/hold=%b, required 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    idle(1);
    tests++;
    if ({cpu_hold, bus.byte_ready, bus.imem_we, done, error} !== 5'b10000 ||
        bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: hold/ready/we/done/err=%b addr=%h wdata=%h, required 10000 00 00000000",
               {cpu_hold, bus.byte_ready, bus.imem_we, done, error}, bus.imem_addr, bus.imem_wdata);
    end
    reset = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h33;
    idle(6);
    bus.byte_valid = 1'b0;
    tests++;
    if (got_addr.size() != 0 || bus.byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_quiet: writes=%0d ready=%b hold=%b, required 0 0 1", got_addr.size(), bus.byte_ready, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_chk();
    test_len_err();
    test_gaps_and_random();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
